maxnet_controller: RTL and testbench

Sequencer for the 4-node Maxnet winner-take-all datapath. Fetches the four input activations from the data memory (2-bit address, combinational 32-bit read), then iterates lateral inhibition x_i ← max(0, x_i − (Σ_{j≠i} x_j >> EPS_SHIFT)) in parallel across nodes until one node survives. It reports the winner index and value with a done pulse, and sits between the top-level start/result interface and the data memory.

---
 rtl/maxnet_pkg.sv | 11 +
 rtl/maxnet_pe.sv | 18 +
 rtl/maxnet_controller.sv | 181 ++++++++++++++++++
 tb/tb_maxnet_controller.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and sizes for the 4-node Maxnet winner-take-all sequencer.
package maxnet_pkg;
  localparam int NODES  = 4;
  localparam int ADDR_W = 2;
  localparam int ITER_W = 8;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  // One bit per node, e.g. which nodes still hold a nonzero activation.
  typedef logic [NODES-1:0] node_mask_t;
endpackage

// File: rtl/maxnet_pe.sv
// One Maxnet node update: x_next = max(0, x - (others_sum >> EPS_SHIFT)).
module maxnet_pe #(
  parameter int DATA_W    = 32,
  parameter int EPS_SHIFT = 3
) (
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W+1:0] i_others_sum,
  output logic [DATA_W-1:0] o_x_next
);
  logic [DATA_W+1:0] w_inhib;
  logic [DATA_W+1:0] w_own;

  assign w_inhib = i_others_sum >> EPS_SHIFT;
  assign w_own   = {2'b00, i_x};

  // Inhibition below own value fits in DATA_W, so the low slice is exact.
  assign o_x_next = (w_inhib >= w_own) ? '0 : (i_x - w_inhib[DATA_W-1:0]);
endmodule

// File: rtl/maxnet_controller.sv
// Maxnet sequencer: loads 4 activations, iterates lateral inhibition, reports the winner.
// Optional iter_count port enabled by defining MAXNET_ITER_COUNT_EN.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int EPS_SHIFT = 3,
  parameter int MAX_ITER  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] winner,
  output logic [DATA_W-1:0] winner_value,
  output logic              tie,
  output logic              timeout
`ifdef MAXNET_ITER_COUNT_EN
  ,
  output logic [ITER_W-1:0] iter_count
`endif
);
  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_load_cnt;
  logic [ITER_W-1:0] r_iter_cnt;
  logic [ADDR_W-1:0] r_winner;
  logic [DATA_W-1:0] r_winner_value;
  logic              r_tie;
  logic              r_timeout;

  logic [DATA_W-1:0] w_node   [NODES];
  logic [DATA_W-1:0] w_next   [NODES];
  logic [DATA_W+1:0] w_others [NODES];
  logic [DATA_W+1:0] w_sum;
  node_mask_t        w_nz;
  logic              w_single;
  logic              w_same;
  logic              w_next_zero;
  logic [ADDR_W-1:0] w_max_idx;
  logic [DATA_W-1:0] w_max_val;

  logic w_clear, w_load_node, w_update, w_finish, w_set_tie, w_set_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < NODES; gi++) begin : g_node
      logic [DATA_W-1:0] r_x;

      assign w_node[gi]   = r_x;
      assign w_nz[gi]     = |r_x;
      assign w_others[gi] = w_sum - {2'b00, r_x};

      maxnet_pe #(.DATA_W(DATA_W), .EPS_SHIFT(EPS_SHIFT)) u_pe (
        .i_x          (r_x),
        .i_others_sum (w_others[gi]),
        .o_x_next     (w_next[gi])
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                             r_x <= '0;
        else if (w_clear)                                    r_x <= '0;
        else if (w_load_node && r_load_cnt == ADDR_W'(gi))   r_x <= mem_data;
        else if (w_update)                                   r_x <= w_next[gi];
      end
    end
  endgenerate

  // Two extra bits keep the four-way sum from overflowing.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NODES; i++) w_sum = w_sum + {2'b00, w_node[i]};
  end

  // Strict '>' keeps the lowest index among equal maxima.
  always_comb begin
    w_max_idx   = '0;
    w_max_val   = w_node[0];
    w_same      = 1'b1;
    w_next_zero = 1'b1;
    for (int i = 0; i < NODES; i++) begin
      if (w_node[i] > w_max_val) begin
        w_max_idx = ADDR_W'(i);
        w_max_val = w_node[i];
      end
      if (w_next[i] != w_node[i]) w_same = 1'b0;
      if (w_next[i] != '0) w_next_zero = 1'b0;
    end
  end

  assign w_single = ((w_nz & (w_nz - node_mask_t'(1))) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_clear       = 1'b0;
    w_load_node   = 1'b0;
    w_update      = 1'b0;
    w_finish      = 1'b0;
    w_set_tie     = 1'b0;
    w_set_timeout = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear      = 1'b1;
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        busy        = 1'b1;
        w_load_node = 1'b1;
        if (r_load_cnt == ADDR_W'(NODES - 1)) w_state_next = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (w_single) begin
          w_finish  = 1'b1;
          w_set_tie = (w_nz == '0);
        end else if (r_iter_cnt == ITER_W'(MAX_ITER)) begin
          w_finish      = 1'b1;
          w_set_timeout = 1'b1;
        end else if (w_next_zero || w_same) begin
          w_finish  = 1'b1;
          w_set_tie = 1'b1;
        end else begin
          w_update = 1'b1;
        end
        if (w_finish) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Load counter wraps back to 0 after the last node, so mem_addr idles at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_cnt     <= '0;
      r_iter_cnt     <= '0;
      r_winner       <= '0;
      r_winner_value <= '0;
      r_tie          <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      if (w_clear) begin
        r_iter_cnt <= '0;
        r_tie      <= 1'b0;
        r_timeout  <= 1'b0;
      end
      if (w_load_node) r_load_cnt <= r_load_cnt + ADDR_W'(1);
      if (w_update)    r_iter_cnt <= r_iter_cnt + ITER_W'(1);
      if (w_finish) begin
        r_winner       <= w_max_idx;
        r_winner_value <= w_max_val;
        r_tie          <= w_set_tie;
        r_timeout      <= w_set_timeout;
      end
    end
  end

  assign mem_addr     = r_load_cnt;
  assign winner       = r_winner;
  assign winner_value = r_winner_value;
  assign tie          = r_tie;
  assign timeout      = r_timeout;
`ifdef MAXNET_ITER_COUNT_EN
  assign iter_count   = r_iter_cnt;
`endif
endmodule

// File: tb/tb_maxnet_controller.sv
// Bench for maxnet_controller: two instances (MAX_ITER=255 and MAX_ITER=2) share stimulus.
module tb_maxnet_controller;
  localparam int DW  = 32;
  localparam int EPS = 3;
  localparam int BUDGET = 300;

  typedef struct {
    int              lat;
    int              winner;
    longint unsigned value;
    bit              tie;
    bit              timeout;
    int              n;
  } exp_t;

  typedef struct {
    logic [3:0][31:0] m;
    exp_t             ea;
    exp_t             eb;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start;
  logic [31:0] mem [4];

  logic [1:0]  addr_a, addr_b, win_a, win_b;
  logic [31:0] data_a, data_b, val_a, val_b;
  logic        busy_a, busy_b, done_a, done_b, tie_a, tie_b, to_a, to_b;
`ifdef MAXNET_ITER_COUNT_EN
  logic [7:0]  ic_a, ic_b;
`endif

  assign data_a = mem[addr_a];
  assign data_b = mem[addr_b];

  always #5 clk = ~clk;

  maxnet_controller #(.DATA_W(DW), .EPS_SHIFT(EPS), .MAX_ITER(255)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mem_addr(addr_a), .mem_data(data_a),
    .busy(busy_a), .done(done_a), .winner(win_a), .winner_value(val_a),
    .tie(tie_a), .timeout(to_a)
`ifdef MAXNET_ITER_COUNT_EN
    , .iter_count(ic_a)
`endif
  );

  maxnet_controller #(.DATA_W(DW), .EPS_SHIFT(EPS), .MAX_ITER(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mem_addr(addr_b), .mem_data(data_b),
    .busy(busy_b), .done(done_b), .winner(win_b), .winner_value(val_b),
    .tie(tie_b), .timeout(to_b)
`ifdef MAXNET_ITER_COUNT_EN
    , .iter_count(ic_b)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int run_no   = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int lat, input int w, input longint unsigned v,
                              input bit t, input bit to, input int n);
    exp_t e;
    e.lat = lat; e.winner = w; e.value = v; e.tie = t; e.timeout = to; e.n = n;
    return e;
  endfunction

  // Reference behaviour of the inhibition loop, written from the algorithm description.
  function automatic exp_t model(input logic [3:0][31:0] m, input int max_iter);
    exp_t e;
    longint unsigned x[4], nx[4], s, d;
    int nz, n;
    bit same, allz;
    n = 0; e.tie = 0; e.timeout = 0;
    for (int i = 0; i < 4; i++) x[i] = m[i];
    for (int k = 0; k < 1000; k++) begin
      nz = 0;
      for (int i = 0; i < 4; i++) if (x[i] != 0) nz++;
      if (nz <= 1) begin e.tie = (nz == 0); break; end
      if (n == max_iter) begin e.timeout = 1; break; end
      s = x[0] + x[1] + x[2] + x[3];
      same = 1; allz = 1;
      for (int i = 0; i < 4; i++) begin
        d = (s - x[i]) >> EPS;
        nx[i] = (d >= x[i]) ? 0 : x[i] - d;
        if (nx[i] != x[i]) same = 0;
        if (nx[i] != 0) allz = 0;
      end
      if (same || allz) begin e.tie = 1; break; end
      for (int i = 0; i < 4; i++) x[i] = nx[i];
      n++;
    end
    e.winner = 0; e.value = x[0];
    for (int i = 1; i < 4; i++) if (x[i] > e.value) begin e.winner = i; e.value = x[i]; end
    e.n = n; e.lat = 6 + n;
    return e;
  endfunction

  function automatic logic [3:0][31:0] pack4(input logic [31:0] a, b, c, d);
    logic [3:0][31:0] m;
    m[0] = a; m[1] = b; m[2] = c; m[3] = d;
    return m;
  endfunction

  task automatic compare(input string tag, input exp_t e, input int cyc,
                         input logic [1:0] w, input logic [31:0] v, input logic t,
                         input logic to, input logic [7:0] ic);
    chk({tag, "_latency"}, cyc, e.lat);
    chk({tag, "_winner"}, w, e.winner);
    chk({tag, "_value"}, v, e.value);
    chk({tag, "_tie"}, t, e.tie);
    chk({tag, "_timeout"}, to, e.timeout);
`ifdef MAXNET_ITER_COUNT_EN
    chk({tag, "_iter_count"}, ic, e.n);
`else
    if (ic != 8'd0) $display("note: unexpected iter_count argument");
`endif
  endtask

  // Starts a run in the current cycle; extra[c] re-raises start in cycle c.
  task automatic run(input logic [3:0][31:0] m, input exp_t ea, input exp_t eb,
                     input logic [31:0] extra);
    exp_t e;
    bit got_a, got_b;
    logic [7:0] ica, icb;
    for (int i = 0; i < 4; i++) mem[i] = m[i];
    q_a.push_back(ea);
    q_b.push_back(eb);
    got_a = 0; got_b = 0;
    run_no++;
    start = 1'b1;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("busy_idle_cycle0", busy_a, 1'b0);
      if (cyc >= 1 && cyc <= 4) begin
        chk("load_busy", busy_a, 1'b1);
        chk("load_addr", addr_a, cyc - 1);
      end
`ifdef MAXNET_ITER_COUNT_EN
      ica = ic_a; icb = ic_b;
`else
      ica = 8'd0; icb = 8'd0;
`endif
      if (done_a && !got_a) begin
        e = q_a.pop_front();
        got_a = 1;
        chk("done_busy_low", busy_a, 1'b0);
        compare("a", e, cyc, win_a, val_a, tie_a, to_a, ica);
        $display("run %0d dutA mem=%0d,%0d,%0d,%0d cycle=%0d winner=%0d value=%0d tie=%0b timeout=%0b",
                 run_no, m[0], m[1], m[2], m[3], cyc, win_a, val_a, tie_a, to_a);
      end
      if (done_b && !got_b) begin
        e = q_b.pop_front();
        got_b = 1;
        compare("b", e, cyc, win_b, val_b, tie_b, to_b, icb);
        $display("run %0d dutB mem=%0d,%0d,%0d,%0d cycle=%0d winner=%0d value=%0d tie=%0b timeout=%0b",
                 run_no, m[0], m[1], m[2], m[3], cyc, win_b, val_b, tie_b, to_b);
      end
      if (got_a && got_b) break;
      @(posedge clk); #1;
      start = (cyc + 1 < 32) ? extra[cyc + 1] : 1'b0;
    end
    if (!got_a) begin
      n_checks++; n_errors++;
      $display("FAIL done_a_wait actual=no_done required=done_within_%0d", BUDGET);
      void'(q_a.pop_front());
    end
    if (!got_b) begin
      n_checks++; n_errors++;
      $display("FAIL done_b_wait actual=no_done required=done_within_%0d", BUDGET);
      void'(q_b.pop_front());
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_pulse_width", {done_a, done_b}, 2'b00);
    chk("idle_after_done", busy_a, 1'b0);
    chk("result_hold", val_a, ea.value);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_outs"}, {addr_a, busy_a, done_a, win_a, tie_a, to_a}, '0);
    chk({tag, "_a_value"}, val_a, '0);
    chk({tag, "_b_outs"}, {addr_b, busy_b, done_b, win_b, tie_b, to_b}, '0);
    chk({tag, "_b_value"}, val_b, '0);
`ifdef MAXNET_ITER_COUNT_EN
    chk({tag, "_iter_count"}, {ic_a, ic_b}, '0);
`endif
  endtask

  vec_t vecs[6];
  logic [3:0][31:0] rm;

  initial begin
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = '0;

    vecs[0].m = pack4(10, 20, 30, 40);
    vecs[0].ea = mk(14, 3, 25, 0, 0, 8);  vecs[0].eb = mk(8, 3, 29, 0, 1, 2);
    vecs[1].m = pack4(0, 0, 7, 0);
    vecs[1].ea = mk(6, 2, 7, 0, 0, 0);    vecs[1].eb = mk(6, 2, 7, 0, 0, 0);
    vecs[2].m = pack4(5, 5, 0, 0);
    vecs[2].ea = mk(6, 0, 5, 1, 0, 0);    vecs[2].eb = mk(6, 0, 5, 1, 0, 0);
    vecs[3].m = pack4(0, 0, 0, 0);
    vecs[3].ea = mk(6, 0, 0, 1, 0, 0);    vecs[3].eb = mk(6, 0, 0, 1, 0, 0);
    vecs[4].m = pack4(9, 9, 9, 9);
    vecs[4].ea = mk(10, 0, 2, 1, 0, 4);   vecs[4].eb = mk(8, 0, 4, 0, 1, 2);
    vecs[5].m = pack4(0, 50, 0, 3);
    vecs[5].ea = mk(7, 1, 50, 0, 0, 1);   vecs[5].eb = mk(7, 1, 50, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run(vecs[i].m, vecs[i].ea, vecs[i].eb, 32'd0);

    // Full-scale and random activations, expectations from the reference loop.
    rm = pack4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000);
    run(rm, model(rm, 255), model(rm, 2), 32'd0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++)
        rm[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      run(rm, model(rm, 255), model(rm, 2), 32'd0);
    end

    // Abort mid-run: rst in cycle 3 clears everything at once, and the run does not resume.
    run(vecs[0].m, vecs[0].ea, vecs[0].eb, 32'd0);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_before_rst", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    chk_all_zero("rst_held");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_resume_after_rst", {busy_a, busy_b}, 2'b00);

    // Restart with start re-pulsed in LOAD, ITER and DONE: all ignored.
    run(vecs[5].m, vecs[5].ea, vecs[5].eb, (32'd1 << 2) | (32'd1 << 5) | (32'd1 << 7));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
